// File: rtl/mem_arbiter.sv
// Shares one unified Memory port between instruction fetch (I) and data load/store (D).
// D has priority; a saturating starvation count forces an I grant after STARVE_LIMIT D grants.
module mem_arbiter #(
    parameter int MEM_LATENCY  = 2,
    parameter int STARVE_LIMIT = 4,
    parameter int DATA_W       = 32
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              i_req,
    input  logic [31:0]       i_addr,
    output logic              i_ready,
    output logic [DATA_W-1:0] i_rdata,
    input  logic              d_req,
    input  logic              d_we,
    input  logic [31:0]       d_addr,
    input  logic [DATA_W-1:0] d_wdata,
    output logic              d_ready,
    output logic [DATA_W-1:0] d_rdata,
    output logic [31:0]       mem_addr,
    output logic [DATA_W-1:0] mem_din,
    output logic              mem_read,
    output logic              mem_write,
    input  logic [DATA_W-1:0] mem_dout,
    output logic              busy
);

    localparam int CNT_W  = (MEM_LATENCY > 1) ? $clog2(MEM_LATENCY) : 1;
    localparam int WAIT_W = $clog2(STARVE_LIMIT + 1);

    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_BUSY = 2'd1;
    localparam logic [1:0] ST_RESP = 2'd2;

    localparam logic [CNT_W-1:0]  CNT_LOAD = CNT_W'(MEM_LATENCY - 1);
    localparam logic [WAIT_W-1:0] WAIT_MAX = WAIT_W'(STARVE_LIMIT);

    logic [1:0]        state;
    logic [CNT_W-1:0]  cnt;
    logic              owner_i;
    logic              lat_we;
    logic [31:0]       lat_addr;
    logic [DATA_W-1:0] lat_wdata;
    logic [WAIT_W-1:0] i_wait;
    logic              grant_i;
    logic              in_busy;
    logic              last_cycle;

    function automatic logic [WAIT_W-1:0] sat_inc(input logic [WAIT_W-1:0] v);
        return (v >= WAIT_MAX) ? WAIT_MAX : v + WAIT_W'(1);
    endfunction

    // I wins when it is alone, or when D has starved it long enough.
    assign grant_i    = i_req && (!d_req || (i_wait >= WAIT_MAX));
    assign in_busy    = (state == ST_BUSY);
    assign last_cycle = in_busy && (cnt == '0);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            owner_i   <= 1'b0;
            lat_we    <= 1'b0;
            lat_addr  <= '0;
            lat_wdata <= '0;
            i_wait    <= '0;
            i_rdata   <= '0;
            d_rdata   <= '0;
        end else begin
            case (state)
                ST_IDLE: begin
                    if (i_req || d_req) begin
                        state     <= ST_BUSY;
                        cnt       <= CNT_LOAD;
                        owner_i   <= grant_i;
                        lat_we    <= grant_i ? 1'b0 : d_we;
                        lat_addr  <= grant_i ? i_addr : d_addr;
                        lat_wdata <= grant_i ? '0 : d_wdata;
                        if (grant_i) begin
                            i_wait <= '0;
                        end else if (i_req) begin
                            i_wait <= sat_inc(i_wait);
                        end
                    end
                end
                ST_BUSY: begin
                    if (cnt == '0) begin
                        state <= ST_RESP;
                        if (owner_i) begin
                            i_rdata <= mem_dout;
                        end else begin
                            d_rdata <= lat_we ? '0 : mem_dout;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                ST_RESP: state <= ST_IDLE;
                default: state <= ST_IDLE;
            endcase
        end
    end

    // Memory port is quiet outside BUSY; a store strobes write only on its final cycle.
    assign mem_addr  = in_busy ? lat_addr : '0;
    assign mem_din   = (in_busy && lat_we) ? lat_wdata : '0;
    assign mem_read  = in_busy && !lat_we;
    assign mem_write = last_cycle && lat_we;
    assign i_ready   = (state == ST_RESP) && owner_i;
    assign d_ready   = (state == ST_RESP) && !owner_i;
    assign busy      = (state != ST_IDLE);

endmodule

// File: tb/tb_mem_arbiter.sv
// Bench for mem_arbiter: vector table, hand-written corner sequences and a
// randomized run against a transaction-level reference model.
module tb_mem_arbiter;

    localparam int LAT = 2;
    localparam int SL  = 4;

    logic clk = 1'b0;
    logic reset;
    always #5 clk = ~clk;

    logic        i_req, i_ready, d_req, d_we, d_ready;
    logic [31:0] i_addr, i_rdata, d_addr, d_wdata, d_rdata;
    logic [31:0] mem_addr, mem_din, mem_dout;
    logic        mem_read, mem_write, busy;

    mem_arbiter #(.MEM_LATENCY(LAT), .STARVE_LIMIT(SL), .DATA_W(32)) dut (
        .clk(clk), .reset(reset),
        .i_req(i_req), .i_addr(i_addr), .i_ready(i_ready), .i_rdata(i_rdata),
        .d_req(d_req), .d_we(d_we), .d_addr(d_addr), .d_wdata(d_wdata),
        .d_ready(d_ready), .d_rdata(d_rdata),
        .mem_addr(mem_addr), .mem_din(mem_din), .mem_read(mem_read),
        .mem_write(mem_write), .mem_dout(mem_dout), .busy(busy)
    );

    // Memory device: asynchronous read, synchronous write, plus a bench preload port.
    logic [31:0] mem [16];
    logic [31:0] refmem [16];
    logic        pre_we;
    logic [3:0]  pre_idx;
    logic [31:0] pre_data;
    always @(posedge clk) begin
        if (mem_write) mem[mem_addr[5:2]] <= mem_din;
        else if (pre_we) mem[pre_idx] <= pre_data;
    end
    assign mem_dout = mem[mem_addr[5:2]];

    // Second instance with single-cycle latency and a pattern-generating memory.
    logic        b_i_ready, b_d_req, b_d_ready, b_mem_read, b_mem_write, b_busy;
    logic [31:0] b_i_rdata, b_d_addr, b_d_rdata, b_mem_addr, b_mem_din, b_mem_dout;
    logic        b_d_we;
    assign b_mem_dout = b_mem_addr ^ 32'hA5A5_0000;

    mem_arbiter #(.MEM_LATENCY(1), .STARVE_LIMIT(SL), .DATA_W(32)) dut_b (
        .clk(clk), .reset(reset),
        .i_req(1'b0), .i_addr(32'h0), .i_ready(b_i_ready), .i_rdata(b_i_rdata),
        .d_req(b_d_req), .d_we(b_d_we), .d_addr(b_d_addr), .d_wdata(32'h0),
        .d_ready(b_d_ready), .d_rdata(b_d_rdata),
        .mem_addr(b_mem_addr), .mem_din(b_mem_din), .mem_read(b_mem_read),
        .mem_write(b_mem_write), .mem_dout(b_mem_dout), .busy(b_busy)
    );

    int n_cmp = 0;
    int n_fail = 0;

    task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic chk1(input string name, input logic act, input logic exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %b expected %b", name, act, exp);
        end
    endtask

    task automatic chkint(input string name, input int act, input int exp);
        n_cmp++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    task automatic preload(input int idx, input logic [31:0] val);
        pre_we = 1'b1; pre_idx = 4'(idx); pre_data = val; refmem[idx] = val;
        @(posedge clk); #1;
        pre_we = 1'b0;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        repeat (2) @(posedge clk);
        #1 reset = 1'b0;
    endtask

    task automatic chk_all_zero(input string tag);
        chk1({tag, " i_ready"}, i_ready, 1'b0);
        chk1({tag, " d_ready"}, d_ready, 1'b0);
        chk1({tag, " busy"}, busy, 1'b0);
        chk1({tag, " mem_read"}, mem_read, 1'b0);
        chk1({tag, " mem_write"}, mem_write, 1'b0);
        chk32({tag, " mem_addr"}, mem_addr, 32'h0);
        chk32({tag, " mem_din"}, mem_din, 32'h0);
        chk32({tag, " i_rdata"}, i_rdata, 32'h0);
        chk32({tag, " d_rdata"}, d_rdata, 32'h0);
    endtask

    typedef struct {
        bit          is_i;
        bit          we;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [31:0] exp_rdata;
        int          exp_nrd;
        int          exp_nwr;
    } vec_t;

    // One complete access from an idle arbiter; observations relative to request cycle T (c=0).
    task automatic single_access(input vec_t v, output int lat, output logic [31:0] rdata,
                                 output int nrd, output int nwr, output int wr_at,
                                 output logic [31:0] wr_addr, output logic [31:0] wr_data,
                                 output int nbusy, output int other);
        lat = -1; rdata = 32'h0; nrd = 0; nwr = 0; wr_at = -1;
        wr_addr = 32'h0; wr_data = 32'h0; nbusy = 0; other = 0;
        @(posedge clk); #1;
        if (v.is_i) begin
            i_req = 1'b1; i_addr = v.addr;
        end else begin
            d_req = 1'b1; d_we = v.we; d_addr = v.addr; d_wdata = v.wdata;
        end
        for (int c = 0; c < 12; c++) begin
            @(negedge clk);
            if (mem_read) nrd++;
            if (mem_write) begin nwr++; wr_at = c; wr_addr = mem_addr; wr_data = mem_din; end
            if (busy) nbusy++;
            if (v.is_i ? d_ready : i_ready) other++;
            if ((v.is_i ? i_ready : d_ready) && lat < 0) begin
                lat = c;
                rdata = v.is_i ? i_rdata : d_rdata;
            end
            @(posedge clk); #1;
            if (lat >= 0) begin
                i_req = 1'b0; d_req = 1'b0;
                break;
            end
        end
        i_req = 1'b0; d_req = 1'b0;
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "timeout");
    end

    initial begin
        vec_t tbl[8];
        int lat, nrd, nwr, wr_at, nbusy, other;
        logic [31:0] rdata, wr_addr, wr_data;

        tbl[0] = '{1'b0, 1'b0, 32'h10, 32'h0,        32'hDEADBEEF, 2, 0};
        tbl[1] = '{1'b0, 1'b1, 32'h20, 32'h12345678, 32'h0,        0, 1};
        tbl[2] = '{1'b0, 1'b0, 32'h20, 32'h0,        32'h12345678, 2, 0};
        tbl[3] = '{1'b1, 1'b0, 32'h00, 32'h0,        32'hCAFEF00D, 2, 0};
        tbl[4] = '{1'b1, 1'b0, 32'h22, 32'h0,        32'h12345678, 2, 0};
        tbl[5] = '{1'b0, 1'b1, 32'h3C, 32'hA5A55A5A, 32'h0,        0, 1};
        tbl[6] = '{1'b0, 1'b0, 32'h3C, 32'h0,        32'hA5A55A5A, 2, 0};
        tbl[7] = '{1'b1, 1'b0, 32'h3C, 32'h0,        32'hA5A55A5A, 2, 0};

        reset = 1'b1;
        i_req = 1'b0; i_addr = 32'h0; d_req = 1'b0; d_we = 1'b0; d_addr = 32'h0; d_wdata = 32'h0;
        b_d_req = 1'b0; b_d_we = 1'b0; b_d_addr = 32'h0;
        pre_we = 1'b0; pre_idx = 4'h0; pre_data = 32'h0;

        for (int i = 0; i < 16; i++) preload(i, 32'h1000_0000 + 32'(i));
        preload(4, 32'hDEADBEEF);
        preload(0, 32'hCAFEF00D);
        @(negedge clk);
        chk_all_zero("reset");
        @(posedge clk); #1 reset = 1'b0;

        // Vector table of single accesses.
        for (int r = 0; r < 8; r++) begin
            single_access(tbl[r], lat, rdata, nrd, nwr, wr_at, wr_addr, wr_data, nbusy, other);
            chkint($sformatf("row%0d ready latency", r), lat, LAT + 1);
            chk32($sformatf("row%0d rdata", r), rdata, tbl[r].exp_rdata);
            chkint($sformatf("row%0d mem_read cycles", r), nrd, tbl[r].exp_nrd);
            chkint($sformatf("row%0d mem_write cycles", r), nwr, tbl[r].exp_nwr);
            chkint($sformatf("row%0d busy cycles", r), nbusy, LAT + 1);
            chkint($sformatf("row%0d other ready", r), other, 0);
            if (tbl[r].we) begin
                chkint($sformatf("row%0d write cycle", r), wr_at, LAT);
                chk32($sformatf("row%0d write addr", r), wr_addr, tbl[r].addr);
                chk32($sformatf("row%0d write data", r), wr_data, tbl[r].wdata);
            end
        end
        chk32("d_rdata hold across I access", d_rdata, 32'hA5A55A5A);

        // Request dropped right after grant still completes.
        begin
            int dl = -1; int nr = 0; logic [31:0] drd = 32'h0;
            @(posedge clk); #1;
            d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
            for (int c = 0; c < 9; c++) begin
                @(negedge clk);
                if (d_ready) begin nr++; if (dl < 0) begin dl = c; drd = d_rdata; end end
                @(posedge clk); #1;
                d_req = 1'b0;
            end
            chkint("dropped req ready latency", dl, LAT + 1);
            chkint("dropped req ready count", nr, 1);
            chk32("dropped req rdata", drd, 32'hDEADBEEF);
        end

        // Both requesters held high: grant order shows starvation relief.
        begin
            bit exp_i [10] = '{0, 0, 0, 0, 1, 0, 0, 0, 0, 1};
            bit got_i [10];
            int ng = 0;
            do_reset();
            @(posedge clk); #1;
            i_req = 1'b1; i_addr = 32'h0; d_req = 1'b1; d_we = 1'b0; d_addr = 32'h10;
            for (int c = 0; c < 80 && ng < 10; c++) begin
                @(negedge clk);
                if (i_ready && d_ready) chk1("both ready together", 1'b1, 1'b0);
                if (i_ready || d_ready) begin got_i[ng] = i_ready; ng++; end
                @(posedge clk); #1;
            end
            i_req = 1'b0; d_req = 1'b0;
            chkint("starvation grant count", ng, 10);
            for (int g = 0; g < 10; g++)
                if (g < ng) chk1($sformatf("grant %0d is I", g), got_i[g], exp_i[g]);
            do_reset();
        end

        // Reset on the first BUSY cycle of a store.
        begin
            int nrdy = 0; int nwr5 = 0;
            preload(12, 32'h0BAD0BAD);
            @(posedge clk); #1;
            d_req = 1'b1; d_we = 1'b1; d_addr = 32'h30; d_wdata = 32'hFFFF0000;
            @(negedge clk);
            chk1("abort idle mem_write", mem_write, 1'b0);
            @(posedge clk); #1;
            reset = 1'b1; d_req = 1'b0;
            @(negedge clk);
            chk1("abort first busy state", busy, 1'b1);
            chk1("abort first busy mem_write", mem_write, 1'b0);
            @(posedge clk); #1 reset = 1'b0;
            @(negedge clk);
            chk_all_zero("after abort");
            for (int c = 0; c < 6; c++) begin
                @(posedge clk); #1;
                @(negedge clk);
                if (d_ready) nrdy++;
                if (mem_write) nwr5++;
            end
            chkint("abort d_ready count", nrdy, 0);
            chkint("abort mem_write count", nwr5, 0);
            chk32("abort memory untouched", mem[12], 32'h0BAD0BAD);
        end

        // Randomized traffic against a transaction-level model.
        begin
            bit cv = 0; int cg = 0; bit c_i = 0; bit c_we = 0;
            logic [31:0] c_addr = 0, c_wd = 0, c_val = 0, e_i_rd = 0, e_d_rd = 0;
            int iw = 0; int d_rdy_cyc = -10; int i_rdy_cyc = -10;
            bit in_b, last, rsp;
            do_reset();
            for (int i = 0; i < 16; i++) preload(i, $urandom);
            for (int k = 0; k < 400; k++) begin
                if (d_req && k == d_rdy_cyc + 1) d_req = 1'b0;
                else if (!d_req && $urandom_range(0, 2) == 0) begin
                    d_req = 1'b1; d_we = 1'($urandom_range(0, 1));
                    d_addr = 32'($urandom_range(0, 63)); d_wdata = $urandom;
                end
                if (i_req && k == i_rdy_cyc + 1) i_req = 1'b0;
                else if (!i_req && $urandom_range(0, 2) == 0) begin
                    i_req = 1'b1; i_addr = 32'($urandom_range(0, 63));
                end
                if (cv && k > cg + LAT + 1) cv = 0;
                if (!cv && (i_req || d_req)) begin
                    c_i = i_req && (!d_req || iw >= SL);
                    if (c_i) iw = 0;
                    else if (i_req) iw = (iw + 1 > SL) ? SL : iw + 1;
                    c_we = c_i ? 1'b0 : d_we;
                    c_addr = c_i ? i_addr : d_addr;
                    c_wd = d_wdata;
                    if (c_we) begin refmem[c_addr[5:2]] = c_wd; c_val = 32'h0; end
                    else c_val = refmem[c_addr[5:2]];
                    cg = k; cv = 1;
                    if (c_i) i_rdy_cyc = k + LAT + 1; else d_rdy_cyc = k + LAT + 1;
                end
                @(negedge clk);
                in_b = cv && k >= cg + 1 && k <= cg + LAT;
                last = cv && k == cg + LAT;
                rsp  = cv && k == cg + LAT + 1;
                if (rsp) begin if (c_i) e_i_rd = c_val; else e_d_rd = c_val; end
                chk1("rand busy", busy, in_b || rsp);
                chk1("rand mem_read", mem_read, in_b && !c_we);
                chk1("rand mem_write", mem_write, last && c_we);
                chk1("rand i_ready", i_ready, rsp && c_i);
                chk1("rand d_ready", d_ready, rsp && !c_i);
                chk32("rand i_rdata", i_rdata, e_i_rd);
                chk32("rand d_rdata", d_rdata, e_d_rd);
                if (!in_b) begin
                    chk32("rand idle mem_addr", mem_addr, 32'h0);
                    chk32("rand idle mem_din", mem_din, 32'h0);
                end
                if (last) chk32("rand mem_addr", mem_addr, c_addr);
                if (last && c_we) chk32("rand mem_din", mem_din, c_wd);
                @(posedge clk); #1;
            end
            i_req = 1'b0; d_req = 1'b0;
            do_reset();
        end

        // Single-cycle latency, D request held one cycle past ready.
        begin
            int r1 = -1; int r2 = -1; int nrdy = 0; int nrd = 0;
            @(posedge clk); #1;
            b_d_req = 1'b1; b_d_we = 1'b0; b_d_addr = 32'h40;
            for (int c = 0; c < 10; c++) begin
                @(negedge clk);
                if (b_d_ready) begin
                    nrdy++;
                    if (r1 < 0) r1 = c; else if (r2 < 0) r2 = c;
                    chk32("lat1 d_rdata", b_d_rdata, 32'hA5A50040);
                    chk1("lat1 busy in resp", b_busy, 1'b1);
                end
                if (b_mem_read) nrd++;
                else begin
                    chk32("lat1 idle mem_addr", b_mem_addr, 32'h0);
                    chk32("lat1 idle mem_din", b_mem_din, 32'h0);
                end
                chk1("lat1 i_ready", b_i_ready, 1'b0);
                chk1("lat1 mem_write", b_mem_write, 1'b0);
                @(posedge clk); #1;
                if (c == 3) b_d_req = 1'b0;
            end
            chkint("lat1 first ready", r1, 2);
            chkint("lat1 second ready", r2, 5);
            chkint("lat1 ready count", nrdy, 2);
            chkint("lat1 mem_read cycles", nrd, 2);
            chk32("lat1 i_rdata", b_i_rdata, 32'h0);
        end

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end

endmodule
